// File: rtl/block_receiver.sv
// Core-side endpoint of the block dispatch protocol: latches a block assignment, launches lanes, reports completion.
// Optional macro BLOCK_RECEIVER_CYCLE_COUNT_EN adds a saturating 32-bit busy-cycle counter output.
module block_receiver #(
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [7:0]                           block_id,
  input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
  input  logic [THREADS_PER_BLOCK-1:0]         thread_ret,
  input  logic                                 mem_busy,
  output logic                                 launch,
  output logic [THREADS_PER_BLOCK-1:0]         thread_enable,
  output logic [7:0]                           block_idx,
  output logic [15:0]                          thread_base_id,
  output logic [$clog2(THREADS_PER_BLOCK):0]   active_threads,
  output logic                                 done
`ifdef BLOCK_RECEIVER_CYCLE_COUNT_EN
  ,
  output logic [31:0]                          cycle_count
`endif
);

  localparam int CW    = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int SHIFT = $clog2(THREADS_PER_BLOCK);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, DONE} state_t;

  state_t                       r_state, w_next;
  logic                         r_launch, r_done;
  logic [THREADS_PER_BLOCK-1:0] r_enable, r_retired;
  logic [THREADS_PER_BLOCK-1:0] w_retired, w_mask;
  logic [7:0]                   r_idx;
  logic [15:0]                  r_base;
  logic [CW-1:0]                r_active, w_active;

  always_comb begin
    w_next    = r_state;
    w_retired = r_retired | (thread_ret & r_enable);
    w_active  = (thread_count > CW'(THREADS_PER_BLOCK)) ? CW'(THREADS_PER_BLOCK) : thread_count;
    w_mask    = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      w_mask[i] = (CW'(i) < w_active);
    end
    case (r_state)
      IDLE:    if (start) w_next = (thread_count == '0) ? DONE : LAUNCH;
      LAUNCH:  w_next = RUN;
      // This cycle's pulses count toward completion, saving a cycle of latency.
      RUN:     if (w_retired == r_enable) w_next = DRAIN;
      DRAIN:   if (!mem_busy) w_next = DONE;
      DONE:    if (!start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_launch  <= 1'b0;
      r_done    <= 1'b0;
      r_enable  <= '0;
      r_retired <= '0;
      r_idx     <= '0;
      r_base    <= '0;
      r_active  <= '0;
    end else begin
      r_state  <= w_next;
      r_launch <= (w_next == LAUNCH);
      r_done   <= (w_next == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx    <= block_id;
            r_base   <= 16'(block_id) << SHIFT;
            r_active <= w_active;
            r_enable <= w_mask;
          end
        end
        LAUNCH:  r_retired <= '0;
        RUN:     r_retired <= w_retired;
        DONE: begin
          if (!start) begin
            r_enable  <= '0;
            r_retired <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BLOCK_RECEIVER_CYCLE_COUNT_EN
  logic [31:0] r_cycles;

  // Counts every cycle spent in LAUNCH/RUN/DRAIN; idle keeps it cleared so LAUNCH starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycles <= '0;
    end else begin
      case (r_state)
        IDLE:    r_cycles <= '0;
        DONE:    if (!start) r_cycles <= '0;
        default: if (r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
      endcase
    end
  end

  assign cycle_count = r_cycles;
`endif

  assign launch         = r_launch;
  assign done           = r_done;
  assign thread_enable  = r_enable;
  assign block_idx      = r_idx;
  assign thread_base_id = r_base;
  assign active_threads = r_active;

endmodule

// File: tb/tb_block_receiver.sv
// Self-checking bench for block_receiver: directed and randomized blocks against a timing model derived from retire schedules.
// Define BLOCK_RECEIVER_CYCLE_COUNT_EN to also check the optional cycle counter.
module tb_block_receiver;

  localparam int T  = 4;
  localparam int CW = $clog2(T) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    blockId;
  logic [CW-1:0] threadCount;
  logic [T-1:0]  threadRet;
  logic          memBusy;
  logic          launch;
  logic [T-1:0]  threadEnable;
  logic [7:0]    blockIdx;
  logic [15:0]   threadBaseId;
  logic [CW-1:0] activeThreads;
  logic          done;
`ifdef BLOCK_RECEIVER_CYCLE_COUNT_EN
  logic [31:0]   cycleCount;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int retEdge[T];

  block_receiver #(.THREADS_PER_BLOCK(T)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .block_id(blockId),
    .thread_count(threadCount),
    .thread_ret(threadRet),
    .mem_busy(memBusy),
    .launch(launch),
    .thread_enable(threadEnable),
    .block_idx(blockIdx),
    .thread_base_id(threadBaseId),
    .active_threads(activeThreads),
    .done(done)
`ifdef BLOCK_RECEIVER_CYCLE_COUNT_EN
    , .cycle_count(cycleCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Edge 0 samples start; edge 1 is the launch cycle; a lane retires at its scheduled edge (>= 2).
  // done rises after the edge following the last retire plus the busy cycles held after it.
  task automatic applyStimulus(input logic [7:0] id, input logic [CW-1:0] tc, input int busy, input bit noise);
    int           act, lastRet, doneEdge;
    logic [T-1:0] mask, ret;
    logic [15:0]  base;
    act      = (int'(tc) > T) ? T : int'(tc);
    mask     = T'((1 << act) - 1);
    base     = 16'(int'(id) * T);
    lastRet  = 1;
    for (int i = 0; i < act; i++) if (retEdge[i] > lastRet) lastRet = retEdge[i];
    doneEdge = (act == 0) ? 0 : lastRet + busy + 1;

    start = 1'b1; blockId = id; threadCount = tc; threadRet = '0; memBusy = 1'b0;
    tick();
    checkOutput("launch0", 32'(launch), 32'(act != 0));
    checkOutput("done0", 32'(done), 32'(act == 0));
    checkOutput("enable0", 32'(threadEnable), 32'(mask));
    checkOutput("blockIdx", 32'(blockIdx), 32'(id));
    checkOutput("baseId", 32'(threadBaseId), 32'(base));
    checkOutput("active", 32'(activeThreads), 32'(act));

    for (int e = 1; e <= doneEdge + 2; e++) begin
      ret = '0;
      for (int l = 0; l < T; l++) begin
        if (l >= act)               ret[l] = noise;
        else if (e == 1)            ret[l] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        else if (e == retEdge[l])   ret[l] = 1'b1;
        else if (e > retEdge[l])    ret[l] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      threadRet = ret;
      if (e > lastRet && e <= lastRet + busy) memBusy = 1'b1;
      else if (e > lastRet)                   memBusy = 1'b0;
      else                                    memBusy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      checkOutput("launch", 32'(launch), 32'(0));
      checkOutput("done", 32'(done), 32'(e >= doneEdge));
      checkOutput("enable", 32'(threadEnable), 32'(mask));
    end
`ifdef BLOCK_RECEIVER_CYCLE_COUNT_EN
    checkOutput("cycleCount", cycleCount, 32'(doneEdge));
`endif

    start = 1'b0; threadRet = '0; memBusy = 1'b0;
    tick();
    checkOutput("doneClear", 32'(done), 32'(0));
    checkOutput("enableClear", 32'(threadEnable), 32'(0));
    checkOutput("idxHeld", 32'(blockIdx), 32'(id));
    checkOutput("baseHeld", 32'(threadBaseId), 32'(base));
`ifdef BLOCK_RECEIVER_CYCLE_COUNT_EN
    checkOutput("cycleClear", cycleCount, 32'(0));
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; blockId = '0; threadCount = '0; threadRet = '0; memBusy = 1'b0;
    tick(); tick();
    checkOutput("rstLaunch", 32'(launch), 32'(0));
    checkOutput("rstEnable", 32'(threadEnable), 32'(0));
    checkOutput("rstIdx", 32'(blockIdx), 32'(0));
    checkOutput("rstBase", 32'(threadBaseId), 32'(0));
    checkOutput("rstActive", 32'(activeThreads), 32'(0));
    checkOutput("rstDone", 32'(done), 32'(0));
    reset = 1'b0;
    tick();

    // Full block, all lanes retire together five cycles after launch.
    for (int i = 0; i < T; i++) retEdge[i] = 6;
    applyStimulus(8'd3, CW'(4), 0, 1'b0);

    // Three lanes retiring out of order with the disabled lane pulsing throughout.
    retEdge[0] = 3; retEdge[2] = 5; retEdge[1] = 7; retEdge[3] = 0;
    applyStimulus(8'd9, CW'(3), 0, 1'b1);

    // Two lanes, memory stays busy for four cycles after the last retire.
    retEdge[0] = 2; retEdge[1] = 4;
    applyStimulus(8'd17, CW'(2), 4, 1'b0);

    // Empty block goes straight to done.
    applyStimulus(8'd5, CW'(0), 0, 1'b0);

    // Saturated thread count and maximum block id.
    for (int i = 0; i < T; i++) retEdge[i] = int'($urandom_range(2, 9));
    applyStimulus(8'd255, CW'(7), 2, 1'b1);

    // Reset in the middle of RUN must clear everything immediately.
    for (int i = 0; i < T; i++) retEdge[i] = 20;
    start = 1'b1; blockId = 8'd42; threadCount = CW'(4);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    checkOutput("midRstLaunch", 32'(launch), 32'(0));
    checkOutput("midRstEnable", 32'(threadEnable), 32'(0));
    checkOutput("midRstIdx", 32'(blockIdx), 32'(0));
    checkOutput("midRstBase", 32'(threadBaseId), 32'(0));
    checkOutput("midRstActive", 32'(activeThreads), 32'(0));
    checkOutput("midRstDone", 32'(done), 32'(0));
    start = 1'b0;
    tick();
    #2 reset = 1'b0;
    tick(); tick();
    checkOutput("postRstDone", 32'(done), 32'(0));
    checkOutput("postRstLaunch", 32'(launch), 32'(0));
    checkOutput("postRstEnable", 32'(threadEnable), 32'(0));

    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < T; i++) retEdge[i] = int'($urandom_range(2, 10));
      applyStimulus(8'($urandom_range(0, 255)), CW'($urandom_range(0, 7)), int'($urandom_range(0, 5)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
